// File: rtl/servo_pkg.sv
// Shared servo definitions: default timing parameters, decoder FSM states and a
// helper that sizes counters from those parameters.
package servo_pkg;

   localparam int unsigned MIN_PULSE_DEF     = 10000;
   localparam int unsigned STEP_DEF          = 40;
   localparam int unsigned MAX_PULSE_DEF     = 25000;
   localparam int unsigned FRAME_TIMEOUT_DEF = 200000;

   typedef enum logic [2:0] {
      SYNC_LOW,
      WAIT_RISE,
      OFFSET,
      STEPS,
      WAIT_LOW
   } servo_state_e;

   // Bits needed to hold any value 0..max(a, b) without wrapping.
   function automatic int unsigned cnt_bits(input int unsigned a, input int unsigned b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/servo_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input followed by a registered
// edge detector; rise and fall are single-cycle events on the synchronized level.
module servo_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = pwm_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // NOTE: sequential state is always assigned with <=, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM decoder: times each high pulse, maps its width to an 8-bit position,
// rejects out-of-range pulses and reports loss of signal.
module servo_pulse_decoder
   import servo_pkg::*;
#(
   parameter int unsigned MIN_PULSE     = MIN_PULSE_DEF,
   parameter int unsigned STEP          = STEP_DEF,
   parameter int unsigned MAX_PULSE     = MAX_PULSE_DEF,
   parameter int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pwm_in,
   output logic [7:0] position,
   output logic       valid,
   output logic       pulse_err,
   output logic       timeout
);

   localparam int unsigned CNT_W = cnt_bits(MAX_PULSE, FRAME_TIMEOUT);
   localparam int unsigned PRE_W = cnt_bits(STEP, 1);

   localparam logic [CNT_W-1:0] FLUSH       = CNT_W'(2);
   localparam logic [CNT_W-1:0] OFFSET_LAST = CNT_W'(MIN_PULSE - 1);
   localparam logic [CNT_W-1:0] MAX_W       = CNT_W'(MAX_PULSE);
   localparam logic [CNT_W-1:0] FRAME_MAX   = CNT_W'(FRAME_TIMEOUT);
   localparam logic [PRE_W-1:0] PRESC_LAST  = PRE_W'(STEP - 1);

   logic level, rise, fall;

   servo_sync_edge u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   servo_state_e     state_q, state_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [7:0]       steps_q, steps_d;
   logic [7:0]       position_q, position_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             timeout_q, timeout_d;

   // SYNC_LOW first lets the reset zeros flush out of the synchronizer, then waits
   // for a genuine low so a pulse already in progress is never decoded.
   // NOTE: every always_comb assigns each output a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SYNC_LOW:  if (width_q >= FLUSH && !level) state_d = WAIT_RISE;
         WAIT_RISE: if (rise) state_d = OFFSET;
         OFFSET: begin
            if (fall)                        state_d = WAIT_RISE;
            else if (width_q == OFFSET_LAST) state_d = STEPS;
         end
         STEPS: begin
            if (fall)                  state_d = WAIT_RISE;
            else if (width_q == MAX_W) state_d = WAIT_LOW;
         end
         WAIT_LOW:  if (fall) state_d = WAIT_RISE;
         default:   state_d = SYNC_LOW;
      endcase
   end

   always_comb begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         OFFSET: err_d = fall;
         STEPS: begin
            if (fall)                  valid_d = 1'b1;
            else if (width_q == MAX_W) err_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // width_q counts high cycles including the rise cycle, so on the fall cycle it equals W.
   always_comb begin
      width_d = width_q;
      presc_d = presc_q;
      steps_d = steps_q;
      unique case (state_q)
         SYNC_LOW: if (width_q < FLUSH) width_d = width_q + CNT_W'(1);
         WAIT_RISE: begin
            if (rise) width_d = CNT_W'(1);
         end
         OFFSET: begin
            if (!fall) width_d = width_q + CNT_W'(1);
            presc_d = '0;
            steps_d = '0;
         end
         STEPS: begin
            if (!fall) begin
               if (width_q != MAX_W) width_d = width_q + CNT_W'(1);
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  if (steps_q != 8'd255) steps_d = steps_q + 8'd1;
               end else begin
                  presc_d = presc_q + PRE_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // timeout is sticky: once the frame counter saturates it stays up until a pulse decodes.
   always_comb begin
      position_d = valid_d ? steps_q : position_q;
      if (rise)                    frame_d = '0;
      else if (frame_q == FRAME_MAX) frame_d = frame_q;
      else                         frame_d = frame_q + CNT_W'(1);
      timeout_d = timeout_q;
      if (frame_d == FRAME_MAX) timeout_d = 1'b1;
      if (valid_d)              timeout_d = 1'b0;
   end

   // NOTE: every flop, counters included, takes the async reset; there is no RAM here to exempt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SYNC_LOW;
         width_q    <= '0;
         frame_q    <= '0;
         presc_q    <= '0;
         steps_q    <= '0;
         position_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         frame_q    <= frame_d;
         presc_q    <= presc_d;
         steps_q    <= steps_d;
         position_q <= position_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         timeout_q  <= timeout_d;
      end
   end

   assign position  = position_q;
   assign valid     = valid_q;
   assign pulse_err = err_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Randomized bench for servo_pulse_decoder: pulse widths are scored against a
// width-to-position model evaluated directly from the decoding rules.
module tb_servo_pulse_decoder;

   localparam int MIN_P   = 100;
   localparam int STEP_P  = 3;
   localparam int MAX_P   = 1000;
   localparam int FRAME_P = 3000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pwm_in;
   logic [7:0] position;
   logic       valid;
   logic       pulse_err;
   logic       timeout;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;
   int valid_total = 0;
   int err_total = 0;
   int both_total = 0;
   int err_delay = -1;
   int pwm_rise_cyc = 0;
   int pos_model = 0;
   int tmo_model = 0;
   int v_snap;
   int dir_w [10];

   servo_pulse_decoder #(
      .MIN_PULSE     (MIN_P),
      .STEP          (STEP_P),
      .MAX_PULSE     (MAX_P),
      .FRAME_TIMEOUT (FRAME_P)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_in    (pwm_in),
      .position  (position),
      .valid     (valid),
      .pulse_err (pulse_err),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (valid) valid_total++;
      if (pulse_err) begin
         err_total++;
         err_delay = cyc - pwm_rise_cyc;
      end
      if (valid && pulse_err) both_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Decoding rule: widths outside [MIN, MAX] are rejected, otherwise
   // position = min(255, floor((W - MIN) / STEP)).
   task automatic send_pulse(input int w, input int gap);
      int v0, e0, exp_v, exp_e, q;
      v0 = valid_total;
      e0 = err_total;
      @(negedge clk);
      pwm_in = 1'b1;
      pwm_rise_cyc = cyc;
      repeat (w) @(negedge clk);
      pwm_in = 1'b0;
      repeat (gap) @(negedge clk);
      if (w < MIN_P || w > MAX_P) begin
         exp_v = 0;
         exp_e = 1;
      end else begin
         exp_v = 1;
         exp_e = 0;
         q = (w - MIN_P) / STEP_P;
         pos_model = (q > 255) ? 255 : q;
         tmo_model = 0;
      end
      check($sformatf("valid_count w=%0d", w), valid_total - v0, exp_v);
      check($sformatf("err_count w=%0d", w), err_total - e0, exp_e);
      check($sformatf("position w=%0d", w), position, pos_model);
      check($sformatf("timeout w=%0d", w), timeout, tmo_model);
   endtask

   task automatic idle_until(input int since_rise);
      while (cyc - pwm_rise_cyc < since_rise) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset position", position, 0);
      check("reset valid", valid, 0);
      check("reset pulse_err", pulse_err, 0);
      check("reset timeout", timeout, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      dir_w = '{MIN_P, MIN_P + 375, MIN_P + 750, MIN_P + 764, MIN_P + 765,
                MAX_P, MIN_P - 1, MIN_P / 2, MAX_P + 1, MAX_P + 60};
      foreach (dir_w[i]) send_pulse(dir_w[i], 20);
      check("long pulse err timing", (err_delay >= MAX_P && err_delay <= MAX_P + 6), 1);

      for (int i = 0; i < 40; i++)
         send_pulse(int'($urandom_range(1080, 40)), int'($urandom_range(60, 12)));

      send_pulse(MIN_P + 375, 20);
      idle_until(FRAME_P - 10);
      check("timeout before limit", timeout, 0);
      idle_until(FRAME_P + 10);
      tmo_model = 1;
      check("timeout after limit", timeout, 1);
      check("position held in timeout", position, pos_model);
      send_pulse(MIN_P / 2, 20);
      send_pulse(MIN_P + 600, 20);

      idle_until(FRAME_P + 10);
      check("timeout before reset", timeout, 1);
      v_snap = valid_total;
      @(negedge clk);
      pwm_in = 1'b1;
      pwm_rise_cyc = cyc;
      repeat (120) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid reset position", position, 0);
      check("mid reset valid", valid, 0);
      check("mid reset pulse_err", pulse_err, 0);
      check("mid reset timeout", timeout, 0);
      pos_model = 0;
      tmo_model = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      pwm_in = 1'b0;
      repeat (20) @(negedge clk);
      check("no valid for cut pulse", valid_total - v_snap, 0);
      check("position after cut pulse", position, 0);
      send_pulse(MIN_P + 375, 20);

      check("valid and err overlap", both_total, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
